// File: rtl/mem_access_if.sv
// mem_access_if: data-memory bus and handshaked I/O ports
interface mem_access_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, in_ready, out_valid, out_data,
    input  dm_rdata, dm_ack, in_valid, in_data, out_ready
  );
  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, in_ready, out_valid, out_data,
    output dm_rdata, dm_ack, in_valid, in_data, out_ready
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory/IO access stage that stalls the pipeline until the access completes
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   wd_i,
  input  logic         wreg_i,
  input  logic [31:0]  wdata_i,
  input  logic [31:0]  mem_addr_i,
  input  logic         memR_i,
  input  logic         memW_i,
  input  logic         in_i,
  input  logic         out_i,
  mem_access_if.master bus,
  output logic         stall_req,
  output logic [4:0]   wd_o,
  output logic         wreg_o,
  output logic [31:0]  wdata_o,
  output logic         misalign_o
);
  typedef enum logic [1:0] {IDLE, DM, IN, OUT} state_t;
  state_t state, state_n;
  logic is_dm, access, misal, done;
  logic [4:0] wd_n;
  logic wreg_n, mis_n, req_n, we_n, rdy_n, ov_n;
  logic [31:0] wdata_n, addr_n, dwr_n, od_n;
  assign is_dm = memR_i | memW_i;
  assign access = is_dm | in_i | out_i;
  assign misal = is_dm && mem_addr_i[1:0] != 2'b00;
  assign done = state == DM ? bus.dm_ack : state == IN ? bus.in_valid : state == OUT ? bus.out_ready : 1'b0;
  assign stall_req = rst ? 1'b0 : state == IDLE ? access && !misal : !done;
  always_comb begin
    state_n = state;
    wd_n = wd_o;
    wreg_n = 1'b0;
    wdata_n = wdata_o;
    mis_n = 1'b0;
    req_n = bus.dm_req;
    we_n = bus.dm_we;
    addr_n = bus.dm_addr;
    dwr_n = bus.dm_wdata;
    rdy_n = bus.in_ready;
    ov_n = bus.out_valid;
    od_n = bus.out_data;
    if (state == IDLE) begin
      if (!access) begin
        wd_n = wd_i;
        wreg_n = wreg_i;
        wdata_n = wdata_i;
      end else if (misal) begin
        mis_n = 1'b1;
      end else if (is_dm) begin
        state_n = DM;
        req_n = 1'b1;
        we_n = !memR_i;
        addr_n = mem_addr_i;
        dwr_n = wdata_i;
      end else if (in_i) begin
        state_n = IN;
        rdy_n = 1'b1;
      end else begin
        state_n = OUT;
        ov_n = 1'b1;
        od_n = wdata_i;
      end
    end else if (done) begin
      state_n = IDLE;
      req_n = 1'b0;
      rdy_n = 1'b0;
      ov_n = 1'b0;
      wd_n = wd_i;
      if (state == DM && !bus.dm_we) begin
        wdata_n = bus.dm_rdata;
        wreg_n = wreg_i;
      end
      if (state == IN) begin
        wdata_n = bus.in_data;
        wreg_n = wreg_i;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.dm_req <= 1'b0;
      bus.dm_we <= 1'b0;
      bus.dm_addr <= 32'd0;
      bus.dm_wdata <= 32'd0;
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= 32'd0;
      wd_o <= 5'd0;
      wreg_o <= 1'b0;
      wdata_o <= 32'd0;
      misalign_o <= 1'b0;
    end else begin
      state <= state_n;
      bus.dm_req <= req_n;
      bus.dm_we <= we_n;
      bus.dm_addr <= addr_n;
      bus.dm_wdata <= dwr_n;
      bus.in_ready <= rdy_n;
      bus.out_valid <= ov_n;
      bus.out_data <= od_n;
      wd_o <= wd_n;
      wreg_o <= wreg_n;
      wdata_o <= wdata_n;
      misalign_o <= mis_n;
    end
  end
endmodule
